// File: rtl/instr_sequencer_if.sv
// Sequencer <-> instruction RAM / register-file datapath bundle.
// master = sequencer side, slave = memory + datapath side.
interface instr_sequencer_if #(
  parameter int MEM_AW = 8
);
  logic [MEM_AW-1:0] imem_addr;
  logic              imem_rd_en;
  logic [15:0]       imem_rdata;
  logic [7:0]        rx_data;
  logic [1:0]        rx_addr;
  logic [1:0]        ry_addr;
  logic [7:0]        imm;
  logic              reg_we;
  logic [1:0]        alu_op;
  logic              alu_b_sel;
  logic              wb_pc_sel;

  modport master (
    output imem_addr, imem_rd_en, rx_addr, ry_addr, imm,
           reg_we, alu_op, alu_b_sel, wb_pc_sel,
    input  imem_rdata, rx_data
  );

  modport slave (
    input  imem_addr, imem_rd_en, rx_addr, ry_addr, imm,
           reg_we, alu_op, alu_b_sel, wb_pc_sel,
    output imem_rdata, rx_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: FETCH/LATCH/EXEC per instruction, 3 clk each, one write-back in EXEC.
// No backpressure; issue is gated only by run/step, HALT is sticky until rst_n.
module instr_sequencer #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  instr_sequencer_if.master bus,
  output logic [MEM_AW-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_LDPC = 4'b0100;
  localparam logic [3:0] OP_BRZ  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]        state;
  logic [MEM_AW-1:0] pc;
  logic [15:0]       ir;
  logic              one_shot;

  logic [3:0]        opcode;
  logic [MEM_AW-1:0] br_target;
  logic              dec_we;
  logic [1:0]        dec_alu_op;
  logic              dec_b_sel;
  logic              dec_pc_sel;

  assign opcode    = ir[15:12];
  assign br_target = MEM_AW'(ir[7:0]);

  // pc is already pc+1 during EXEC, so a not-taken BRZ needs no action here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      ir            <= '0;
      retired_count <= '0;
      one_shot      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
          end else if (step) begin
            state    <= S_FETCH;
            one_shot <= 1'b1;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ir    <= bus.imem_rdata;
          pc    <= pc + MEM_AW'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          retired_count <= retired_count + 16'd1;
          if (opcode == OP_BRZ && bus.rx_data == 8'h00) begin
            pc <= br_target;
          end
          if (opcode == OP_HALT) begin
            state <= S_HALT;
          end else if (run && !one_shot) begin
            state <= S_FETCH;
          end else begin
            state    <= S_IDLE;
            one_shot <= 1'b0;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_we     = 1'b0;
    dec_alu_op = 2'b00;
    dec_b_sel  = 1'b0;
    dec_pc_sel = 1'b0;
    if (state == S_EXEC) begin
      case (opcode)
        OP_LOAD: begin
          dec_we    = 1'b1;
          dec_b_sel = 1'b1;
        end
        OP_MOV:  dec_we = 1'b1;
        OP_ADD: begin
          dec_we     = 1'b1;
          dec_alu_op = 2'b01;
        end
        OP_XOR: begin
          dec_we     = 1'b1;
          dec_alu_op = 2'b10;
        end
        OP_LDPC: begin
          dec_we     = 1'b1;
          dec_pc_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.imem_rd_en = (state == S_FETCH);
  assign bus.rx_addr    = ir[11:10];
  assign bus.ry_addr    = ir[9:8];
  assign bus.imm        = ir[7:0];
  assign bus.reg_we     = dec_we;
  assign bus.alu_op     = dec_alu_op;
  assign bus.alu_b_sel  = dec_b_sel;
  assign bus.wb_pc_sel  = dec_pc_sel;

  assign pc_out = pc;
  assign busy   = (state == S_FETCH) || (state == S_LATCH) || (state == S_EXEC);
  assign halted = (state == S_HALT);

endmodule
